// File: rtl/control_pipe.sv
// control_pipe: registered, handshaked instruction decoder.
// Accepts {opcode, funct, reg_s_t_equal} from fetch and presents one registered
// control bundle to execute. After a LW/SW bundle is consumed, issue is blocked
// for MEM_WAIT cycles. After a taken branch, the next KILL_SLOTS accepted
// instructions are turned into NOPs. Illegal encodings issue a NOP and pulse
// `illegal` for one cycle.
// Optional feature macro: CONTROL_JUMP_EN (adds J / JAL decode; when it is
// undefined, opcodes 0x02/0x03 decode as illegal).
module control_pipe #(
    parameter int MEM_WAIT   = 2,
    parameter int KILL_SLOTS = 0,
    parameter int MEM_BYTES  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [5:0]           opcode,
    input  logic [5:0]           funct,
    input  logic                 reg_s_t_equal,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [3:0]           alu_op,
    output logic [1:0]           alu_a_sel,
    output logic                 alu_b_sel,
    output logic [MEM_BYTES-1:0] mem_we,
    output logic                 reg_d_we,
    output logic                 reg_d_addr_sel,
    output logic                 reg_d_data_sel,
    output logic                 pc_we,
    output logic                 illegal
);

    // ALU operation codes
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_SLT = 4'd4;
    localparam logic [3:0] ALU_SLL = 4'd5;
    localparam logic [3:0] ALU_SRL = 4'd6;
    localparam logic [3:0] ALU_SRA = 4'd7;
    localparam logic [3:0] ALU_LUI = 4'd8;

    // ALU operand selects; A_LINK feeds the return address for JAL
    localparam logic [1:0] A_RS    = 2'd0;
    localparam logic [1:0] A_SHAMT = 2'd1;
    localparam logic [1:0] A_LINK  = 2'd2;
    localparam logic       B_RT    = 1'b0;
    localparam logic       B_IMM   = 1'b1;

    // Destination register and writeback selects
    localparam logic DST_RT   = 1'b0;
    localparam logic DST_RD   = 1'b1;
    localparam logic WB_ALU   = 1'b0;
    localparam logic WB_MEM   = 1'b1;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes
    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_SRA = 6'h03;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // Counter sizing; the kill counter covers 0..3 slots
    localparam int                WAIT_W    = (MEM_WAIT < 2) ? 1 : $clog2(MEM_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(MEM_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
    localparam logic [1:0]        KILL_LOAD = 2'(KILL_SLOTS);
    localparam logic              HAS_WAIT  = (MEM_WAIT > 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_MEMW  = 2'd2
    } state_t;

    // Internal control bundle; is_mem/illegal are bookkeeping, not driven to execute
    typedef struct packed {
        logic [3:0] alu_op;
        logic [1:0] alu_a_sel;
        logic       alu_b_sel;
        logic       mem_wr;
        logic       reg_d_we;
        logic       addr_sel;
        logic       data_sel;
        logic       pc_we;
        logic       is_mem;
        logic       illegal;
    } ctrl_t;

    // Canonical NOP bundle: SLL with no side effects
    function automatic ctrl_t nop_ctrl();
        ctrl_t c;
        c.alu_op    = ALU_SLL;
        c.alu_a_sel = A_RS;
        c.alu_b_sel = B_RT;
        c.mem_wr    = 1'b0;
        c.reg_d_we  = 1'b0;
        c.addr_sel  = DST_RT;
        c.data_sel  = WB_ALU;
        c.pc_we     = 1'b0;
        c.is_mem    = 1'b0;
        c.illegal   = 1'b0;
        return c;
    endfunction

    // Full decode of one instruction; unknown encodings give a NOP flagged illegal
    function automatic ctrl_t decode(input logic [5:0] op, input logic [5:0] fn,
                                     input logic eq);
        ctrl_t c;
        c = nop_ctrl();
        case (op)
            OP_RTYPE: begin
                c.reg_d_we = 1'b1;
                c.addr_sel = DST_RD;
                case (fn)
                    FN_ADD:  c.alu_op = ALU_ADD;
                    FN_SUB:  c.alu_op = ALU_SUB;
                    FN_AND:  c.alu_op = ALU_AND;
                    FN_OR:   c.alu_op = ALU_OR;
                    FN_SLT:  c.alu_op = ALU_SLT;
                    FN_SLL: begin
                        c.alu_op    = ALU_SLL;
                        c.alu_a_sel = A_SHAMT;
                    end
                    FN_SRL: begin
                        c.alu_op    = ALU_SRL;
                        c.alu_a_sel = A_SHAMT;
                    end
                    FN_SRA: begin
                        c.alu_op    = ALU_SRA;
                        c.alu_a_sel = A_SHAMT;
                    end
                    default: begin
                        c         = nop_ctrl();
                        c.illegal = 1'b1;
                    end
                endcase
            end
            OP_ADDI: begin
                c.alu_op    = ALU_ADD;
                c.alu_b_sel = B_IMM;
                c.reg_d_we  = 1'b1;
            end
            OP_ORI: begin
                c.alu_op    = ALU_OR;
                c.alu_b_sel = B_IMM;
                c.reg_d_we  = 1'b1;
            end
            OP_LUI: begin
                c.alu_op    = ALU_LUI;
                c.alu_b_sel = B_IMM;
                c.reg_d_we  = 1'b1;
            end
            OP_LW: begin
                c.alu_op    = ALU_ADD;
                c.alu_b_sel = B_IMM;
                c.reg_d_we  = 1'b1;
                c.data_sel  = WB_MEM;
                c.is_mem    = 1'b1;
            end
            OP_SW: begin
                c.alu_op    = ALU_ADD;
                c.alu_b_sel = B_IMM;
                c.mem_wr    = 1'b1;
                c.is_mem    = 1'b1;
            end
            OP_BEQ: begin
                c.alu_op = ALU_SUB;
                c.pc_we  = eq;
            end
            OP_BNE: begin
                c.alu_op = ALU_SUB;
                c.pc_we  = ~eq;
            end
`ifdef CONTROL_JUMP_EN
            OP_J: begin
                c.pc_we = 1'b1;
            end
            OP_JAL: begin
                c.alu_op    = ALU_ADD;
                c.alu_a_sel = A_LINK;
                c.pc_we     = 1'b1;
                c.reg_d_we  = 1'b1;
                c.addr_sel  = DST_RD;
            end
`endif
            default: begin
                c         = nop_ctrl();
                c.illegal = 1'b1;
            end
        endcase
        return c;
    endfunction

    state_t            state_r;
    ctrl_t             bundle_r;
    logic              out_valid_r;
    logic              illegal_r;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic [1:0]        kill_cnt_r;

    ctrl_t             dec_s;
    ctrl_t             issue_s;
    logic [1:0]        kill_nxt_s;
    logic              in_ready_s;
    logic              accept_s;

    // Handshake, kill-slot substitution and next kill count for an accept
    always_comb begin
        dec_s      = decode(opcode, funct, reg_s_t_equal);
        in_ready_s = (state_r == ST_IDLE) ||
                     ((state_r == ST_ISSUE) && out_ready && !bundle_r.is_mem);
        accept_s   = in_valid && in_ready_s;
        if (kill_cnt_r != 2'd0) begin
            issue_s    = nop_ctrl();
            kill_nxt_s = kill_cnt_r - 2'd1;
        end else if (dec_s.pc_we) begin
            issue_s    = dec_s;
            kill_nxt_s = KILL_LOAD;
        end else begin
            issue_s    = dec_s;
            kill_nxt_s = 2'd0;
        end
    end

    // Issue FSM with bundle, memory-wait and kill-slot registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            bundle_r    <= nop_ctrl();
            out_valid_r <= 1'b0;
            illegal_r   <= 1'b0;
            wait_cnt_r  <= '0;
            kill_cnt_r  <= 2'd0;
        end else begin
            illegal_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_r     <= ST_ISSUE;
                        out_valid_r <= 1'b1;
                        bundle_r    <= issue_s;
                        illegal_r   <= issue_s.illegal;
                        kill_cnt_r  <= kill_nxt_s;
                    end else begin
                        state_r     <= ST_IDLE;
                        out_valid_r <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    if (out_ready) begin
                        if (bundle_r.is_mem && HAS_WAIT) begin
                            state_r     <= ST_MEMW;
                            out_valid_r <= 1'b0;
                            wait_cnt_r  <= WAIT_LOAD;
                        end else if (accept_s) begin
                            state_r     <= ST_ISSUE;
                            out_valid_r <= 1'b1;
                            bundle_r    <= issue_s;
                            illegal_r   <= issue_s.illegal;
                            kill_cnt_r  <= kill_nxt_s;
                        end else begin
                            state_r     <= ST_IDLE;
                            out_valid_r <= 1'b0;
                        end
                    end else begin
                        state_r     <= ST_ISSUE;
                        out_valid_r <= 1'b1;
                    end
                end
                ST_MEMW: begin
                    out_valid_r <= 1'b0;
                    if (wait_cnt_r <= WAIT_ONE) begin
                        state_r    <= ST_IDLE;
                        wait_cnt_r <= '0;
                    end else begin
                        state_r    <= ST_MEMW;
                        wait_cnt_r <= wait_cnt_r - WAIT_ONE;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    out_valid_r <= 1'b0;
                    wait_cnt_r  <= '0;
                end
            endcase
        end
    end

    assign in_ready       = in_ready_s;
    assign out_valid      = out_valid_r;
    assign illegal        = illegal_r;
    assign alu_op         = bundle_r.alu_op;
    assign alu_a_sel      = bundle_r.alu_a_sel;
    assign alu_b_sel      = bundle_r.alu_b_sel;
    assign mem_we         = {MEM_BYTES{bundle_r.mem_wr}};
    assign reg_d_we       = bundle_r.reg_d_we;
    assign reg_d_addr_sel = bundle_r.addr_sel;
    assign reg_d_data_sel = bundle_r.data_sel;
    assign pc_we          = bundle_r.pc_we;

endmodule

// File: tb/tb_control_pipe.sv
// Directed testbench for control_pipe (MEM_WAIT=2, KILL_SLOTS=1, MEM_BYTES=4).
// The control bundle is compared as one packed vector:
// {alu_op, alu_a_sel, alu_b_sel, mem_we, reg_d_we, reg_d_addr_sel, reg_d_data_sel, pc_we}
module tb_control_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       reg_s_t_equal;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] alu_op;
    logic [1:0] alu_a_sel;
    logic       alu_b_sel;
    logic [3:0] mem_we;
    logic       reg_d_we;
    logic       reg_d_addr_sel;
    logic       reg_d_data_sel;
    logic       pc_we;
    logic       illegal;
    logic [14:0] bnd;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    control_pipe #(.MEM_WAIT(2), .KILL_SLOTS(1), .MEM_BYTES(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct(funct), .reg_s_t_equal(reg_s_t_equal),
        .out_valid(out_valid), .out_ready(out_ready), .alu_op(alu_op),
        .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .mem_we(mem_we),
        .reg_d_we(reg_d_we), .reg_d_addr_sel(reg_d_addr_sel),
        .reg_d_data_sel(reg_d_data_sel), .pc_we(pc_we), .illegal(illegal)
    );

    assign bnd = {alu_op, alu_a_sel, alu_b_sel, mem_we, reg_d_we,
                  reg_d_addr_sel, reg_d_data_sel, pc_we};

    function automatic logic [14:0] mk(input logic [3:0] op, input logic [1:0] a,
                                       input logic b, input logic [3:0] mw,
                                       input logic we, input logic ad,
                                       input logic dt, input logic pc);
        return {op, a, b, mw, we, ad, dt, pc};
    endfunction

    // Hand-computed bundles
    logic [14:0] NOP_B, ADD_B, ADDI_B, LW_B, SW_B;
    logic [14:0] BR_T_B, BR_N_B;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic put(input logic [5:0] op, input logic [5:0] fn, input logic eq);
        in_valid      = 1'b1;
        opcode        = op;
        funct         = fn;
        reg_s_t_equal = eq;
    endtask

    // Present one instruction, advance one cycle, check the issued bundle
    task automatic issue_chk(input string tag, input logic [5:0] op, input logic [5:0] fn,
                             input logic eq, input logic [14:0] exp_b, input logic exp_ill);
        put(op, fn, eq);
        step();
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_bnd"}, {17'd0, bnd}, {17'd0, exp_b});
        check({tag, "_ill"}, {31'd0, illegal}, {31'd0, exp_ill});
    endtask

    initial begin
        NOP_B  = mk(4'd5, 2'd0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        ADD_B  = mk(4'd0, 2'd0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        ADDI_B = mk(4'd0, 2'd0, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        LW_B   = mk(4'd0, 2'd0, 1'b1, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0);
        SW_B   = mk(4'd0, 2'd0, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
        BR_T_B = mk(4'd1, 2'd0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        BR_N_B = mk(4'd1, 2'd0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);

        rst = 1'b1; in_valid = 1'b0; opcode = 6'h00; funct = 6'h00;
        reg_s_t_equal = 1'b0; out_ready = 1'b1;
        step(); step();
        rst = 1'b0;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_illegal", {31'd0, illegal}, 32'd0);
        check("rst_bnd", {17'd0, bnd}, {17'd0, NOP_B});

        // ADD: valid one cycle after accept
        issue_chk("add", 6'h00, 6'h20, 1'b0, ADD_B, 1'b0);
        in_valid = 1'b0;
        step();
        check("add_drain", {31'd0, out_valid}, 32'd0);

        // Four ADDI back-to-back
        put(6'h08, 6'h00, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("addi_valid", {31'd0, out_valid}, 32'd1);
            check("addi_ready", {31'd0, in_ready}, 32'd1);
            check("addi_bnd", {17'd0, bnd}, {17'd0, ADDI_B});
        end
        in_valid = 1'b0;
        step();
        check("addi_drain", {31'd0, out_valid}, 32'd0);

        // Remaining decode table entries, issued back-to-back
        issue_chk("ori", 6'h0D, 6'h00, 1'b0, mk(4'd3, 2'd0, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0), 1'b0);
        issue_chk("lui", 6'h0F, 6'h00, 1'b0, mk(4'd8, 2'd0, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0), 1'b0);
        issue_chk("sub", 6'h00, 6'h22, 1'b0, mk(4'd1, 2'd0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0), 1'b0);
        issue_chk("and", 6'h00, 6'h24, 1'b0, mk(4'd2, 2'd0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0), 1'b0);
        issue_chk("or",  6'h00, 6'h25, 1'b0, mk(4'd3, 2'd0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0), 1'b0);
        issue_chk("slt", 6'h00, 6'h2A, 1'b0, mk(4'd4, 2'd0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0), 1'b0);
        issue_chk("sll", 6'h00, 6'h00, 1'b0, mk(4'd5, 2'd1, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0), 1'b0);
        issue_chk("srl", 6'h00, 6'h02, 1'b0, mk(4'd6, 2'd1, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0), 1'b0);
        issue_chk("sra", 6'h00, 6'h03, 1'b0, mk(4'd7, 2'd1, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0), 1'b0);
        in_valid = 1'b0;
        step();

        // LW: in_ready low for exactly two cycles after the handshake
        issue_chk("lw", 6'h23, 6'h00, 1'b0, LW_B, 1'b0);
        check("lw_ready", {31'd0, in_ready}, 32'd0);
        put(6'h00, 6'h20, 1'b0);
        step();
        check("memw1_ready", {31'd0, in_ready}, 32'd0);
        check("memw1_valid", {31'd0, out_valid}, 32'd0);
        step();
        check("memw2_ready", {31'd0, in_ready}, 32'd0);
        check("memw2_valid", {31'd0, out_valid}, 32'd0);
        step();
        check("memw_done_ready", {31'd0, in_ready}, 32'd1);
        check("memw_done_valid", {31'd0, out_valid}, 32'd0);
        step();
        check("post_memw_valid", {31'd0, out_valid}, 32'd1);
        check("post_memw_bnd", {17'd0, bnd}, {17'd0, ADD_B});
        in_valid = 1'b0;
        step();

        // SW, then reset while the wait counter is 1
        issue_chk("sw", 6'h2B, 6'h00, 1'b0, SW_B, 1'b0);
        in_valid = 1'b0;
        step(); step();
        check("sw_wait1_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_memw1_valid", {31'd0, out_valid}, 32'd0);
        check("rst_memw1_ready", {31'd0, in_ready}, 32'd1);
        check("rst_memw1_bnd", {17'd0, bnd}, {17'd0, NOP_B});

        // SW, then reset while the wait counter is 2
        issue_chk("sw2", 6'h2B, 6'h00, 1'b0, SW_B, 1'b0);
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_memw2_ready", {31'd0, in_ready}, 32'd1);
        check("rst_memw2_bnd", {17'd0, bnd}, {17'd0, NOP_B});

        // Branches and kill slot
        issue_chk("beq_taken", 6'h04, 6'h00, 1'b1, BR_T_B, 1'b0);
        issue_chk("killed_add", 6'h00, 6'h20, 1'b0, NOP_B, 1'b0);
        issue_chk("add_after_kill", 6'h00, 6'h20, 1'b0, ADD_B, 1'b0);
        issue_chk("bne_eq", 6'h05, 6'h00, 1'b1, BR_N_B, 1'b0);
        issue_chk("add_after_bne", 6'h00, 6'h20, 1'b0, ADD_B, 1'b0);
        issue_chk("bne_taken", 6'h05, 6'h00, 1'b0, BR_T_B, 1'b0);
        issue_chk("killed_illegal", 6'h3F, 6'h00, 1'b0, NOP_B, 1'b0);
        issue_chk("beq_ne", 6'h04, 6'h00, 1'b0, BR_N_B, 1'b0);
        in_valid = 1'b0;
        step();

        // Illegal opcode held by back-pressure for three cycles
        out_ready = 1'b0;
        issue_chk("ill_op", 6'h3F, 6'h00, 1'b0, NOP_B, 1'b1);
        check("ill_hold_ready0", {31'd0, in_ready}, 32'd0);
        put(6'h00, 6'h20, 1'b0);
        step();
        check("ill_hold1_valid", {31'd0, out_valid}, 32'd1);
        check("ill_hold1_pulse", {31'd0, illegal}, 32'd0);
        check("ill_hold1_ready", {31'd0, in_ready}, 32'd0);
        check("ill_hold1_bnd", {17'd0, bnd}, {17'd0, NOP_B});
        step();
        check("ill_hold2_valid", {31'd0, out_valid}, 32'd1);
        check("ill_hold2_bnd", {17'd0, bnd}, {17'd0, NOP_B});
        out_ready = 1'b1;
        #1;
        check("ill_release_ready", {31'd0, in_ready}, 32'd1);
        step();
        check("after_hold_valid", {31'd0, out_valid}, 32'd1);
        check("after_hold_bnd", {17'd0, bnd}, {17'd0, ADD_B});
        check("after_hold_ill", {31'd0, illegal}, 32'd0);
        in_valid = 1'b0;
        step();
        check("after_hold_drain", {31'd0, out_valid}, 32'd0);

        // Illegal funct, then J (illegal unless jumps are enabled)
        issue_chk("ill_funct", 6'h00, 6'h3F, 1'b0, NOP_B, 1'b1);
`ifdef CONTROL_JUMP_EN
        issue_chk("jump", 6'h02, 6'h00, 1'b0, mk(4'd5, 2'd0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1), 1'b0);
`else
        issue_chk("jump", 6'h02, 6'h00, 1'b0, NOP_B, 1'b1);
`endif
        in_valid = 1'b0;
        step();
        check("final_drain", {31'd0, out_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
